gslcd_v2_0_timing_gen: RTL and testbench
========================================

Name: gslcd_v2_0_timing_gen

Overview:
Programmable LCD raster timing generator, the next generation of the fixed-parameter gslcd timing block. It produces HSYNC/VSYNC/ACTIVE plus frame/line strobes and active-area pixel coordinates for the pixel pipeline. All window bounds are runtime-programmable through shadowed config inputs that take effect only on a frame boundary. Enable/disable is graceful, with frame-aligned stop, and all outputs are registered.

Parameters:
C_H_WIDTH, 11, width of horizontal counter, config fields and PIXEL_X
C_V_WIDTH, 10, width of vertical counter, config fields and PIXEL_Y
C_DEF_HTOTAL, 929, reset value of active HTOTAL (pixels per line, exclusive)
C_DEF_HSYNC_START / C_DEF_HSYNC_END, 40 / 88, reset HSYNC window [start,end)
C_DEF_HACT_START / C_DEF_HACT_END, 128 / 928, reset horizontal active window [start,end)
C_DEF_VTOTAL, 526, reset value of active VTOTAL (lines per frame, exclusive)
C_DEF_VSYNC_START / C_DEF_VSYNC_END, 13 / 16, reset VSYNC window
C_DEF_VACT_START / C_DEF_VACT_END, 45 / 525, reset vertical active window
C_DEF_HSYNC_POL / C_DEF_VSYNC_POL, 0 / 0, reset polarity (1 = active-high)

Ports:
PCLK  in  1  pixel clock
RST  in  1  reset, asynchronous, active-high
EN  in  1  run request
CFG_HTOTAL, CFG_HSYNC_START, CFG_HSYNC_END, CFG_HACT_START, CFG_HACT_END  in  C_H_WIDTH each  staged horizontal config
CFG_VTOTAL, CFG_VSYNC_START, CFG_VSYNC_END, CFG_VACT_START, CFG_VACT_END  in  C_V_WIDTH each  staged vertical config
CFG_HSYNC_POL, CFG_VSYNC_POL  in  1 each  staged polarity
CFG_UPDATE  in  1  single-cycle request to load staged config at the next frame boundary
CFG_PENDING  out  1  update requested but not yet applied
RUNNING  out  1  raster is being generated
HSYNC, VSYNC  out  1 each  sync outputs, polarity applied
ACTIVE  out  1  data-enable
FRAME_START  out  1  one-cycle pulse on the first pixel of a frame
LINE_START  out  1  one-cycle pulse on the first pixel of each line
PIXEL_X  out  C_H_WIDTH  active-area column
PIXEL_Y  out  C_V_WIDTH  active-area row

Behaviour:
- Reset (async assert, sync release): state IDLE; h=v=0; active config = C_DEF_*. Outputs: RUNNING=0, CFG_PENDING=0, ACTIVE=0, FRAME_START=0, LINE_START=0, PIXEL_X=PIXEL_Y=0. HSYNC/VSYNC at the inactive level, i.e. !C_DEF_*_POL.
- FSM states:
  - IDLE: counters held at 0; outputs at idle values as above, using the current active polarity.
  - IDLE -> RUN when EN=1. The staged config is loaded the same edge and CFG_PENDING clears. Counting starts from h=v=0 on the next edge.
  - RUN -> STOPPING when EN=0.
  - STOPPING -> RUN if EN returns to 1 before the wrap; no discontinuity.
  - STOPPING -> IDLE at the frame wrap, i.e. the frame always completes.
- Counting in RUN/STOPPING:
  - h increments each PCLK.
  - When h >= HTOTAL-1, h=0 and v increments. HTOTAL-1 saturates at 0, so HTOTAL of 0 or 1 wraps every cycle.
  - When v >= VTOTAL-1 at the h wrap, v=0: this is the frame wrap.
  - Comparisons use >=, so out-of-range values cannot stall.
- Config shadowing:
  - A CFG_UPDATE pulse sets CFG_PENDING.
  - At a frame wrap, if CFG_PENDING or CFG_UPDATE is high, the CFG_* values present that cycle are loaded into the active config and CFG_PENDING clears. A CFG_UPDATE coinciding with the wrap is therefore applied immediately.
  - Active config never changes mid-frame.
- Decode (combinational from h, v and active config, then registered; outputs lag the counters by exactly 1 cycle):
  - hs_win = HSYNC_START <= h < HSYNC_END; HSYNC = hs_win XNOR HSYNC_POL. VSYNC is the same on v.
  - ACTIVE = (HACT_START <= h < HACT_END) && (VACT_START <= v < VACT_END).
  - PIXEL_X = h - HACT_START and PIXEL_Y = v - VACT_START when ACTIVE; both are 0 otherwise.
  - LINE_START = (h==0) while running. FRAME_START = (h==0 && v==0) while running.
  - RUNNING = state != IDLE, registered.
  - An empty window (end <= start) never asserts.
- The output registered from the last counter state before IDLE is the final running sample. The next output cycle shows idle values.
- A mid-frame RST aborts immediately to reset values; no partial-frame completion.

Test Plan:
- Reset then EN=1 with CFG HTOTAL=10, HSYNC [1,3), HACT [4,9), VTOTAL=6, VSYNC [1,2), VACT [2,5), pols=1 -> RUNNING rises 1 cycle after the load edge; LINE_START every 10 cycles; FRAME_START every 60; ACTIVE 5 cycles/line on 3 lines; PIXEL_X 0..4, PIXEL_Y 0..2; HSYNC high 2 cycles/line.
- Same config with pols=0 -> HSYNC/VSYNC exactly inverted; ACTIVE and strobes unchanged; HSYNC=1 while IDLE.
- CFG_UPDATE mid-frame with HTOTAL=12 -> CFG_PENDING=1; line length stays 10 until the frame wrap, then 12; CFG_PENDING=0 after the wrap. CFG_UPDATE on the exact wrap cycle -> applied that wrap, and CFG_PENDING never observed high.
- EN=0 at v=2 -> frame runs to v=5,h=9; RUNNING falls next cycle; counters at 0. EN=0 then back to 1 before the wrap -> no gap in LINE_START cadence.
- RST asserted asynchronously mid-line -> all outputs take reset values without waiting for a PCLK edge; EN=1 afterwards restarts with C_DEF_* timing (HTOTAL=929, VTOTAL=526).
- Degenerate config HTOTAL=1, HACT [5,5) -> LINE_START every cycle; ACTIVE never asserts; no lockup.

Source files
------------

// File: rtl/gslcd_v2_0_timing_gen.sv
// Programmable LCD raster timing generator: HSYNC/VSYNC/ACTIVE, frame/line strobes and
// active-area pixel coordinates. The config is shadowed and applied only at a frame boundary.
module gslcd_v2_0_timing_gen #(
  parameter int C_H_WIDTH         = 11,
  parameter int C_V_WIDTH         = 10,
  parameter int C_DEF_HTOTAL      = 929,
  parameter int C_DEF_HSYNC_START = 40,
  parameter int C_DEF_HSYNC_END   = 88,
  parameter int C_DEF_HACT_START  = 128,
  parameter int C_DEF_HACT_END    = 928,
  parameter int C_DEF_VTOTAL      = 526,
  parameter int C_DEF_VSYNC_START = 13,
  parameter int C_DEF_VSYNC_END   = 16,
  parameter int C_DEF_VACT_START  = 45,
  parameter int C_DEF_VACT_END    = 525,
  parameter bit C_DEF_HSYNC_POL   = 1'b0,
  parameter bit C_DEF_VSYNC_POL   = 1'b0
) (
  input  logic                 i_pclk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic [C_H_WIDTH-1:0] i_cfg_htotal,
  input  logic [C_H_WIDTH-1:0] i_cfg_hsync_start,
  input  logic [C_H_WIDTH-1:0] i_cfg_hsync_end,
  input  logic [C_H_WIDTH-1:0] i_cfg_hact_start,
  input  logic [C_H_WIDTH-1:0] i_cfg_hact_end,
  input  logic [C_V_WIDTH-1:0] i_cfg_vtotal,
  input  logic [C_V_WIDTH-1:0] i_cfg_vsync_start,
  input  logic [C_V_WIDTH-1:0] i_cfg_vsync_end,
  input  logic [C_V_WIDTH-1:0] i_cfg_vact_start,
  input  logic [C_V_WIDTH-1:0] i_cfg_vact_end,
  input  logic                 i_cfg_hsync_pol,
  input  logic                 i_cfg_vsync_pol,
  input  logic                 i_cfg_update,
  output logic                 o_cfg_pending,
  output logic                 o_running,
  output logic                 o_hsync,
  output logic                 o_vsync,
  output logic                 o_active,
  output logic                 o_frame_start,
  output logic                 o_line_start,
  output logic [C_H_WIDTH-1:0] o_pixel_x,
  output logic [C_V_WIDTH-1:0] o_pixel_y
);

  // state      | meaning
  // S_IDLE     | counters held at 0, outputs at idle values
  // S_RUN      | raster generated continuously
  // S_STOPPING | run request dropped, finishing the current frame
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOPPING} state_t;

  state_t r_state, w_state_nxt;

  logic [C_H_WIDTH-1:0] r_h, r_htotal, r_hs_start, r_hs_end, r_hact_start, r_hact_end;
  logic [C_V_WIDTH-1:0] r_v, r_vtotal, r_vs_start, r_vs_end, r_vact_start, r_vact_end;
  logic                 r_hs_pol, r_vs_pol, r_pending;

  logic [C_H_WIDTH-1:0] w_htot_m1;
  logic [C_V_WIDTH-1:0] w_vtot_m1;
  logic w_running, w_h_last, w_v_last, w_frame_wrap, w_load;
  logic w_hs_win, w_vs_win, w_hact, w_vact, w_active;

  // HTOTAL/VTOTAL of 0 or 1 both mean a single position; >= keeps stale counters from stalling
  assign w_htot_m1    = (r_htotal == '0) ? '0 : r_htotal - C_H_WIDTH'(1);
  assign w_vtot_m1    = (r_vtotal == '0) ? '0 : r_vtotal - C_V_WIDTH'(1);
  assign w_running    = (r_state != S_IDLE);
  assign w_h_last     = (r_h >= w_htot_m1);
  assign w_v_last     = (r_v >= w_vtot_m1);
  assign w_frame_wrap = w_running && w_h_last && w_v_last;
  assign w_load       = ((r_state == S_IDLE) && i_en) ||
                        (w_frame_wrap && (r_pending || i_cfg_update));

  assign w_hs_win = (r_h >= r_hs_start)   && (r_h < r_hs_end);
  assign w_vs_win = (r_v >= r_vs_start)   && (r_v < r_vs_end);
  assign w_hact   = (r_h >= r_hact_start) && (r_h < r_hact_end);
  assign w_vact   = (r_v >= r_vact_start) && (r_v < r_vact_end);
  assign w_active = w_running && w_hact && w_vact;

  always_ff @(posedge i_pclk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (i_en) w_state_nxt = S_RUN;
      S_RUN:      if (!i_en) w_state_nxt = S_STOPPING;
      S_STOPPING: begin
        if (i_en)              w_state_nxt = S_RUN;
        else if (w_frame_wrap) w_state_nxt = S_IDLE;
      end
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_pclk or posedge i_rst) begin
    if (i_rst) begin
      r_h          <= '0;
      r_v          <= '0;
      r_pending    <= 1'b0;
      r_htotal     <= C_H_WIDTH'(C_DEF_HTOTAL);
      r_hs_start   <= C_H_WIDTH'(C_DEF_HSYNC_START);
      r_hs_end     <= C_H_WIDTH'(C_DEF_HSYNC_END);
      r_hact_start <= C_H_WIDTH'(C_DEF_HACT_START);
      r_hact_end   <= C_H_WIDTH'(C_DEF_HACT_END);
      r_vtotal     <= C_V_WIDTH'(C_DEF_VTOTAL);
      r_vs_start   <= C_V_WIDTH'(C_DEF_VSYNC_START);
      r_vs_end     <= C_V_WIDTH'(C_DEF_VSYNC_END);
      r_vact_start <= C_V_WIDTH'(C_DEF_VACT_START);
      r_vact_end   <= C_V_WIDTH'(C_DEF_VACT_END);
      r_hs_pol     <= C_DEF_HSYNC_POL;
      r_vs_pol     <= C_DEF_VSYNC_POL;
    end else begin
      if (w_load) begin
        r_htotal     <= i_cfg_htotal;
        r_hs_start   <= i_cfg_hsync_start;
        r_hs_end     <= i_cfg_hsync_end;
        r_hact_start <= i_cfg_hact_start;
        r_hact_end   <= i_cfg_hact_end;
        r_vtotal     <= i_cfg_vtotal;
        r_vs_start   <= i_cfg_vsync_start;
        r_vs_end     <= i_cfg_vsync_end;
        r_vact_start <= i_cfg_vact_start;
        r_vact_end   <= i_cfg_vact_end;
        r_hs_pol     <= i_cfg_hsync_pol;
        r_vs_pol     <= i_cfg_vsync_pol;
        r_pending    <= 1'b0;
      end else if (i_cfg_update) begin
        r_pending <= 1'b1;
      end

      if (!w_running) begin
        r_h <= '0;
        r_v <= '0;
      end else if (w_h_last) begin
        r_h <= '0;
        r_v <= w_v_last ? '0 : r_v + C_V_WIDTH'(1);
      end else begin
        r_h <= r_h + C_H_WIDTH'(1);
      end
    end
  end

  // Outputs lag the counters by one cycle; idle levels follow the active polarity
  always_ff @(posedge i_pclk or posedge i_rst) begin
    if (i_rst) begin
      o_running     <= 1'b0;
      o_hsync       <= ~C_DEF_HSYNC_POL;
      o_vsync       <= ~C_DEF_VSYNC_POL;
      o_active      <= 1'b0;
      o_frame_start <= 1'b0;
      o_line_start  <= 1'b0;
      o_pixel_x     <= '0;
      o_pixel_y     <= '0;
    end else begin
      o_running     <= w_running;
      o_hsync       <= w_running ? (w_hs_win ~^ r_hs_pol) : ~r_hs_pol;
      o_vsync       <= w_running ? (w_vs_win ~^ r_vs_pol) : ~r_vs_pol;
      o_active      <= w_active;
      o_frame_start <= w_running && (r_h == '0) && (r_v == '0);
      o_line_start  <= w_running && (r_h == '0);
      o_pixel_x     <= w_active ? r_h - r_hact_start : '0;
      o_pixel_y     <= w_active ? r_v - r_vact_start : '0;
    end
  end

  assign o_cfg_pending = r_pending;

endmodule

// File: tb/tb_gslcd_v2_0_timing_gen.sv
// Bench for gslcd_v2_0_timing_gen: directed scenarios plus random configs, checked each
// cycle against a frame-position model of the raster.
module tb_gslcd_v2_0_timing_gen;

  typedef struct packed {
    logic [10:0] ht, hss, hse, has, hae;
    logic [9:0]  vt, vss, vse, vas, vae;
    logic        hp, vp;
  } cfg_t;

  typedef struct packed {
    logic run, pend, hs, vs, act, fs, ls;
    logic [10:0] x;
    logic [9:0]  y;
  } out_t;

  logic clk = 1'b0, rst = 1'b1, en = 1'b0, upd = 1'b0;
  cfg_t stg;
  logic o_pend, o_run, o_hs, o_vs, o_act, o_fs, o_ls;
  logic [10:0] o_x;
  logic [9:0]  o_y;
  out_t dut_o;

  assign dut_o = {o_run, o_pend, o_hs, o_vs, o_act, o_fs, o_ls, o_x, o_y};

  gslcd_v2_0_timing_gen dut (
    .i_pclk(clk), .i_rst(rst), .i_en(en),
    .i_cfg_htotal(stg.ht), .i_cfg_hsync_start(stg.hss), .i_cfg_hsync_end(stg.hse),
    .i_cfg_hact_start(stg.has), .i_cfg_hact_end(stg.hae),
    .i_cfg_vtotal(stg.vt), .i_cfg_vsync_start(stg.vss), .i_cfg_vsync_end(stg.vse),
    .i_cfg_vact_start(stg.vas), .i_cfg_vact_end(stg.vae),
    .i_cfg_hsync_pol(stg.hp), .i_cfg_vsync_pol(stg.vp), .i_cfg_update(upd),
    .o_cfg_pending(o_pend), .o_running(o_run), .o_hsync(o_hs), .o_vsync(o_vs),
    .o_active(o_act), .o_frame_start(o_fs), .o_line_start(o_ls),
    .o_pixel_x(o_x), .o_pixel_y(o_y)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0;
  int m_state;   // 0 idle, 1 run, 2 stopping
  int m_pos;     // position within the frame, line-major
  cfg_t m_cfg;
  logic m_pend;
  int c_ls, c_fs, c_act, c_hs, c_vs, c_run, c_pend, max_x, max_y;

  function automatic cfg_t def_cfg();
    cfg_t c;
    c = '{ht:11'd929, hss:11'd40, hse:11'd88, has:11'd128, hae:11'd928,
          vt:10'd526, vss:10'd13, vse:10'd16, vas:10'd45, vae:10'd525, hp:1'b0, vp:1'b0};
    return c;
  endfunction

  function automatic cfg_t cfg_a(logic pol);
    cfg_t c;
    c = '{ht:11'd10, hss:11'd1, hse:11'd3, has:11'd4, hae:11'd9,
          vt:10'd6, vss:10'd1, vse:10'd2, vas:10'd2, vae:10'd5, hp:pol, vp:pol};
    return c;
  endfunction

  function automatic out_t reset_out();
    out_t o;
    o = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    return o;
  endfunction

  function automatic int hlen(cfg_t c);
    return (c.ht <= 11'd1) ? 1 : int'(c.ht);
  endfunction

  function automatic int vlen(cfg_t c);
    return (c.vt <= 10'd1) ? 1 : int'(c.vt);
  endfunction

  function automatic out_t model_out();
    out_t o;
    int h, v;
    logic hw, vw, ha, va;
    o = '0;
    if (m_state == 0) begin
      o.hs = ~m_cfg.hp;
      o.vs = ~m_cfg.vp;
    end else begin
      h  = m_pos % hlen(m_cfg);
      v  = m_pos / hlen(m_cfg);
      hw = (h >= int'(m_cfg.hss)) && (h < int'(m_cfg.hse));
      vw = (v >= int'(m_cfg.vss)) && (v < int'(m_cfg.vse));
      ha = (h >= int'(m_cfg.has)) && (h < int'(m_cfg.hae));
      va = (v >= int'(m_cfg.vas)) && (v < int'(m_cfg.vae));
      o.run = 1'b1;
      o.hs  = (hw == m_cfg.hp);
      o.vs  = (vw == m_cfg.vp);
      o.act = ha && va;
      o.fs  = (m_pos == 0);
      o.ls  = (h == 0);
      if (ha && va) begin
        o.x = 11'(h - int'(m_cfg.has));
        o.y = 10'(v - int'(m_cfg.vas));
      end
    end
    return o;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_pos   = 0;
    m_cfg   = def_cfg();
    m_pend  = 1'b0;
  endtask

  task automatic model_step();
    int   flen;
    logic wrap;
    flen = hlen(m_cfg) * vlen(m_cfg);
    if (m_state == 0) begin
      if (en) begin
        m_cfg = stg; m_pend = 1'b0; m_state = 1; m_pos = 0;
      end else if (upd) m_pend = 1'b1;
    end else begin
      wrap = (m_pos == flen - 1);
      if (wrap) begin
        if (m_pend || upd) begin m_cfg = stg; m_pend = 1'b0; end
        m_pos = 0;
      end else begin
        m_pos++;
        if (upd) m_pend = 1'b1;
      end
      if (m_state == 1) begin
        if (!en) m_state = 2;
      end else if (en) m_state = 1;
      else if (wrap) m_state = 0;
    end
  endtask

  task automatic clear_counts();
    c_ls = 0; c_fs = 0; c_act = 0; c_hs = 0; c_vs = 0; c_run = 0; c_pend = 0;
    max_x = 0; max_y = 0;
  endtask

  task automatic check(string tag, int obs, int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    out_t exp;
    if (rst) begin
      @(posedge clk);
      model_reset();
      exp = model_out();
    end else begin
      exp = model_out();
      @(posedge clk);
      model_step();
    end
    exp.pend = m_pend;
    #1;
    n_vec++;
    assert (dut_o === exp) else begin
      n_bad++;
      $error("FAIL raster t=%0t observed=%h expected=%h", $time, dut_o, exp);
    end
    c_ls += int'(o_ls); c_fs += int'(o_fs); c_act += int'(o_act);
    c_hs += int'(o_hs); c_vs += int'(o_vs); c_run += int'(o_run); c_pend += int'(o_pend);
    if (o_act && int'(o_x) > max_x) max_x = int'(o_x);
    if (o_act && int'(o_y) > max_y) max_y = int'(o_y);
  endtask

  initial begin
    stg = def_cfg();
    model_reset();
    clear_counts();
    repeat (2) tick();
    check("reset_out", int'(dut_o), int'(reset_out()));
    rst = 1'b0;
    tick();

    // Update request while idle, then start with config A (active-high syncs)
    stg = cfg_a(1'b1);
    upd = 1'b1; tick(); upd = 1'b0;
    check("idle_pending", int'(o_pend), 1);
    repeat (2) tick();
    en = 1'b1; tick();
    check("running_at_load", int'(o_run), 0);
    check("pending_cleared_at_load", int'(o_pend), 0);
    tick();
    check("running_rises", int'(o_run), 1);
    check("first_frame_start", int'(o_fs), 1);
    while (m_pos != 0) tick();
    clear_counts();
    repeat (60) tick();
    check("a_line_starts", c_ls, 6);
    check("a_frame_starts", c_fs, 1);
    check("a_active", c_act, 15);
    check("a_hsync_high", c_hs, 12);
    check("a_vsync_high", c_vs, 10);
    check("a_max_x", max_x, 4);
    check("a_max_y", max_y, 2);

    // Inverted polarity, applied at the next frame
    stg = cfg_a(1'b0);
    upd = 1'b1; tick(); upd = 1'b0;
    check("pol_pending", int'(o_pend), 1);
    while (m_pos != 0) tick();
    clear_counts();
    repeat (60) tick();
    check("b_hsync_high", c_hs, 48);
    check("b_vsync_high", c_vs, 50);
    check("b_active", c_act, 15);
    check("b_line_starts", c_ls, 6);
    check("b_pending_seen", c_pend, 0);

    // Mid-frame update to a 12-pixel line
    stg.ht = 11'd12;
    upd = 1'b1; tick(); upd = 1'b0;
    check("ht12_pending", int'(o_pend), 1);
    while (m_pos != 0) tick();
    clear_counts();
    repeat (72) tick();
    check("ht12_line_starts", c_ls, 6);
    check("ht12_frame_starts", c_fs, 1);
    check("ht12_pending_seen", c_pend, 0);

    // Update landing exactly on the wrap cycle
    stg.ht = 11'd10;
    while (m_pos != 71) tick();
    upd = 1'b1; tick(); upd = 1'b0;
    check("wrap_upd_pending", int'(o_pend), 0);
    clear_counts();
    repeat (60) tick();
    check("wrap_upd_line_starts", c_ls, 6);
    check("wrap_upd_pending_seen", c_pend, 0);

    // Graceful stop from v=2
    while (m_pos != 20) tick();
    en = 1'b0;
    clear_counts();
    repeat (45) tick();
    check("stop_running_cycles", c_run, 40);
    check("stop_idle_hsync", int'(o_hs), 1);

    // Stop request withdrawn before the wrap: cadence unbroken
    en = 1'b1;
    repeat (2) tick();
    while (m_pos != 20) tick();
    en = 1'b0;
    repeat (5) tick();
    en = 1'b1;
    clear_counts();
    repeat (120) tick();
    check("resume_line_starts", c_ls, 12);
    check("resume_running", c_run, 120);

    // Random configs, enable toggling and update pulses
    for (int it = 0; it < 40; it++) begin
      stg.ht  = 11'($urandom_range(0, 16));
      stg.hss = 11'($urandom_range(0, 18));
      stg.hse = 11'($urandom_range(0, 18));
      stg.has = 11'($urandom_range(0, 18));
      stg.hae = 11'($urandom_range(0, 18));
      stg.vt  = 10'($urandom_range(0, 7));
      stg.vss = 10'($urandom_range(0, 8));
      stg.vse = 10'($urandom_range(0, 8));
      stg.vas = 10'($urandom_range(0, 8));
      stg.vae = 10'($urandom_range(0, 8));
      stg.hp  = 1'($urandom_range(0, 1));
      stg.vp  = 1'($urandom_range(0, 1));
      for (int k = 0; k < 100; k++) begin
        if ($urandom_range(0, 29) == 0) en = ~en;
        upd = ($urandom_range(0, 19) == 0);
        tick();
      end
      upd = 1'b0;
    end

    // Asynchronous reset mid-line, then restart on default timing
    en = 1'b1;
    repeat (3) tick();
    #3;
    rst = 1'b1;
    #1;
    check("async_reset_out", int'(dut_o), int'(reset_out()));
    en = 1'b0;
    tick();
    stg = def_cfg();
    rst = 1'b0;
    en = 1'b1;
    tick();
    clear_counts();
    repeat (1858) tick();
    check("def_line_starts", c_ls, 2);
    check("def_frame_starts", c_fs, 1);
    check("def_hsync_high", c_hs, 1762);
    check("def_vsync_high", c_vs, 1858);
    check("def_active", c_act, 0);

    // Degenerate config: one-pixel lines, empty active window
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stg = '{ht:11'd1, hss:11'd0, hse:11'd1, has:11'd5, hae:11'd5,
            vt:10'd4, vss:10'd0, vse:10'd1, vas:10'd0, vae:10'd4, hp:1'b1, vp:1'b1};
    tick();
    clear_counts();
    repeat (20) tick();
    check("degen_line_starts", c_ls, 20);
    check("degen_frame_starts", c_fs, 5);
    check("degen_active", c_act, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
